fcvt_pipe: RTL and testbench
============================

// Module: fcvt_pipe
// PURPOSE
//  Pipelined bidirectional FP32 <-> int32 converter, the return path of the FPU add/sub datapath.
//  op=0 (itof): signed int32 -> IEEE-754 single.
//  op=1 (ftoi): single -> signed int32.
//  3-stage valid/ready pipeline between the FPU issue port and the writeback arbiter;
//  full throughput of 1 op/cycle.
// PARAMETERS
//  FTOI_RNE  1  ftoi rounding: 1 = round-to-nearest-even, 0 = truncate toward zero (itof always RNE)
// PORTS
//  clk        in   1   clock; single clock domain
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand valid
//  in_ready   out  1   converter accepts operand this cycle
//  op         in   1   0 = itof, 1 = ftoi; sampled with x
//  x          in   32  operand (int32 or FP32 bits)
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  y          out  32  result
//  ovf        out  1   ftoi only: NaN, +/-Inf or out of int32 range; always 0 for itof
// BEHAVIOUR
//  Reset (sync, active-high): all stage valids=0, out_valid=0, y=0, ovf=0; in-flight ops dropped.
//    in_ready=1 on the first cycle after rst deasserts.
//  Handshake:
//    - transfer when valid & ready.
//    - stage k loads when stage k empty or stage k advancing.
//    - in_ready = !s1_valid | s1_advance (combinational from out_ready through the chain).
//    - y/ovf/out_valid held stable while out_valid & !out_ready.
//  Latency 3 cycles accept->out_valid with out_ready=1; full pipe + out_ready=1 accepts in the same cycle.
//  S1 unpack:
//    - itof: sign, |x| in 32 bits (|-2^31| = 0x80000000), lzc of |x|.
//    - ftoi: sign, exp, {1,m}; flag NaN/Inf (e=FF); denormal/zero forced to 0.
//  S2 align:
//    - itof: left-shift |x| by lzc; exponent = 158 - lzc.
//    - ftoi: shift mantissa by (e-150), keeping guard/round/sticky below bit 0.
//      Shift saturates: e<126 -> all sticky.
//  S3 round/pack:
//    - itof RNE on 24 kept bits (guard, sticky, lsb); mantissa carry-out increments exponent.
//      x=0 -> +0 (0x00000000).
//    - ftoi: round per FTOI_RNE, then apply sign (two's complement).
//      Overflow rule: |rounded| > 2^31-1, except exactly -2^31.
//      Overflow or NaN/Inf -> ovf=1, y=0x7FFFFFFF (pos/NaN) or 0x80000000 (neg).
//  Width rules: exponent arithmetic 9-bit signed; no internal truncation before rounding.
//  No state machine; occupancy is the three stage valid bits only.
// STRUCTURE
//  fpu_pkg:
//    - EXP_BIAS=127, FP_EXP_MAX=8'hFF
//    - INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000
//    - op encoding localparams OP_ITOF/OP_FTOI
//    - typedef for stage payload struct (sign, exp9, mant, grs, flags)
//  Sub-module lzc32: 32-bit leading-zero counter, 6-bit out, 32 for zero;
//    combinational, same priority style as the FPU normaliser.
//  Rest inline: three stage registers with valid, one always_ff per stage.
// TESTING
//  1 itof (out_ready=1): 0x00000001->0x3F800000; 0xFFFFFFFD->0xC0400000; 0->0x00000000; out_valid 3 cycles after accept.
//  2 itof rounding: 0x01000001->0x4B800000 (tie, even); 0x01000003->0x4B800002; 0x7FFFFFFF->0x4F000000; 0x80000000->0xCF000000.
//  3 ftoi RNE: 0x40200000->2; 0x40600000->4; 0xBFC00000->0xFFFFFFFE; 0x3F000000->0; ovf=0 for all.
//  4 ftoi limits: 0x4F000000->0x7FFFFFFF ovf=1; 0xCF000000->0x80000000 ovf=0; 0x7FC00000->0x7FFFFFFF ovf=1; 0xFF800000->0x80000000 ovf=1.
//  5 backpressure: stream 8 ops, out_ready=0 for cycles 4..9 -> in_ready=0 once 3 held; no loss/duplication; y stable while stalled; order preserved.
//  6 rst asserted mid-stream with 3 ops in flight -> next cycle out_valid=0, y=0, in_ready=1; later ops convert correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants, operation encodings and the stage payload type for the
// FP32 <-> int32 converter pipeline.
package fpu_pkg;

  localparam int          EXP_BIAS   = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] INT_MAX    = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN    = 32'h80000000;

  localparam logic OP_ITOF = 1'b0;
  localparam logic OP_FTOI = 1'b1;

  // Exponent of a 32-bit integer whose leading one sits in bit 31.
  localparam logic [8:0] ITOF_EXP0 = 9'(EXP_BIAS + 31);
  // Biased exponent at which the 24-bit significand is an exact integer.
  localparam logic signed [8:0] FTOI_SHIFT0 = 9'(EXP_BIAS + 23);
  // Below this biased exponent the value is < 0.5 and only sticky survives.
  localparam logic signed [8:0] FTOI_STICKY_EXP = 9'(EXP_BIAS - 1);

  // Payload carried between stages. exp9 holds the lzc in S1 for itof,
  // the biased exponent in S1 for ftoi, and the result exponent in S2 for itof.
  typedef struct packed {
    logic        op;
    logic        sign;
    logic [8:0]  exp9;
    logic [31:0] mant;
    logic [2:0]  grs;     // guard, round, sticky
    logic        is_nan;
    logic        is_inf;  // exponent field all ones (Inf or NaN)
    logic        is_zero;
    logic        big;     // ftoi magnitude certainly >= 2^32
  } stage_t;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_up(input logic lsb, input logic [2:0] grs);
    return grs[2] & (grs[1] | grs[0] | lsb);
  endfunction

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] x,
  output logic [5:0]  cnt
);

  // Priority scan from LSB up so the highest set bit wins.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fcvt_pipe.sv
// Three-stage valid/ready converter: signed int32 <-> IEEE-754 single.
// S1 unpacks, S2 aligns, S3 rounds and packs into the output register.
module fcvt_pipe
  import fpu_pkg::*;
#(
  parameter bit FTOI_RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  stage_t s1_reg, s1_next;
  stage_t s2_reg, s2_next;
  logic   s1_valid, s2_valid;
  logic   s1_load, s2_load, s3_load;

  // Each stage loads when it is empty or its contents move on this cycle.
  assign s3_load  = !out_valid | out_ready;
  assign s2_load  = !s2_valid | s3_load;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = s1_load;

  // ---------------- S1: unpack ----------------
  logic [31:0] abs_x;
  logic [5:0]  lzc_x;

  assign abs_x = x[31] ? (~x + 32'd1) : x;

  lzc32 u_lzc (
    .x   (abs_x),
    .cnt (lzc_x)
  );

  // Split the operand into sign / magnitude / exponent and special flags.
  always_comb begin
    s1_next      = '0;
    s1_next.op   = op;
    s1_next.sign = x[31];
    if (op == OP_ITOF) begin
      s1_next.mant    = abs_x;
      s1_next.exp9    = {3'd0, lzc_x};
      s1_next.is_zero = (x == 32'd0);
    end else begin
      s1_next.exp9    = {1'b0, x[30:23]};
      s1_next.is_inf  = (x[30:23] == FP_EXP_MAX);
      s1_next.is_nan  = (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
      s1_next.is_zero = (x[30:23] == 8'd0);
      // Denormals convert to 0, so their significand is dropped here.
      s1_next.mant    = (x[30:23] == 8'd0) ? 32'd0 : {8'd0, 1'b1, x[22:0]};
    end
  end

  // S1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_reg   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_reg <= s1_next;
    end
  end

  // ---------------- S2: align ----------------
  logic [31:0]        norm;
  logic signed [8:0]  sh;
  logic signed [8:0]  nsh;
  logic [4:0]         rsh;
  logic [47:0]        wide;

  // itof: normalise by lzc. ftoi: shift the significand to an integer
  // position, keeping guard/round/sticky for the fraction shifted out.
  always_comb begin
    s2_next = s1_reg;
    norm    = s1_reg.mant << s1_reg.exp9[5:0];
    sh      = $signed(s1_reg.exp9) - FTOI_SHIFT0;
    nsh     = -sh;
    rsh     = nsh[4:0];
    wide    = {s1_reg.mant[23:0], 24'd0} >> rsh;
    if (s1_reg.op == OP_ITOF) begin
      s2_next.exp9 = ITOF_EXP0 - s1_reg.exp9;
      s2_next.mant = {8'd0, norm[31:8]};
      s2_next.grs  = {norm[7], norm[6], |norm[5:0]};
    end else if (!s1_reg.is_inf) begin
      if (sh > 9'sd8) begin
        s2_next.big  = 1'b1;
        s2_next.mant = 32'd0;
      end else if (!sh[8]) begin
        s2_next.mant = s1_reg.mant << sh[3:0];
      end else if ($signed(s1_reg.exp9) < FTOI_STICKY_EXP) begin
        s2_next.mant = 32'd0;
        s2_next.grs  = {2'b00, |s1_reg.mant};
      end else begin
        s2_next.mant = {8'd0, wide[47:24]};
        s2_next.grs  = {wide[23], wide[22], |wide[21:0]};
      end
    end
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_reg   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_reg <= s2_next;
    end
  end

  // ---------------- S3: round / pack ----------------
  logic [24:0] m25;
  logic [8:0]  e9;
  logic [22:0] frac;
  logic [32:0] mag;
  logic        ftoi_up;
  logic [31:0] y_next;
  logic        ovf_next;
  logic        unused_bits;

  assign unused_bits = e9[8];

  // Round, handle the mantissa carry-out, saturate ftoi overflow.
  always_comb begin
    m25      = {1'b0, s2_reg.mant[23:0]} + {24'd0, rne_up(s2_reg.mant[0], s2_reg.grs)};
    e9       = s2_reg.exp9 + {8'd0, m25[24]};
    frac     = m25[24] ? m25[23:1] : m25[22:0];
    ftoi_up  = FTOI_RNE ? rne_up(s2_reg.mant[0], s2_reg.grs) : 1'b0;
    mag      = {1'b0, s2_reg.mant} + {32'd0, ftoi_up};
    y_next   = 32'd0;
    ovf_next = 1'b0;
    if (s2_reg.op == OP_ITOF) begin
      y_next = s2_reg.is_zero ? 32'd0 : {s2_reg.sign, e9[7:0], frac};
    end else if (s2_reg.is_nan) begin
      y_next   = INT_MAX;
      ovf_next = 1'b1;
    end else if (s2_reg.is_inf || s2_reg.big ||
                 ((mag > {1'b0, INT_MAX}) && !(s2_reg.sign && (mag == {1'b0, INT_MIN})))) begin
      y_next   = s2_reg.sign ? INT_MIN : INT_MAX;
      ovf_next = 1'b1;
    end else begin
      y_next = s2_reg.sign ? (~mag[31:0] + 32'd1) : mag[31:0];
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 32'd0;
      ovf       <= 1'b0;
    end else if (s3_load) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        y   <= y_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_fcvt_pipe.sv
// Directed testbench for fcvt_pipe: vector table plus backpressure and
// mid-stream reset sequences.
module tb_fcvt_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_in;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        op;
    logic [31:0] x;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  fcvt_pipe #(.FTOI_RNE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_in),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Send one op into an empty pipe and check latency and result.
  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    op_in     = vecs[i].op;
    x         = vecs[i].x;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = 32'd0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
    check($sformatf("vec%0d latency", i), lat, 32'd3);
    @(negedge clk);
    $display("vec%0d op=%0d x=%h -> y=%h ovf=%0d (expect %h/%0d)",
             i, vecs[i].op, vecs[i].x, y, ovf, vecs[i].y, vecs[i].ovf);
    check($sformatf("vec%0d y", i), y, vecs[i].y);
    check($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
    @(posedge clk);
    #1;
  endtask

  int ids [8] = '{0, 1, 4, 5, 7, 9, 11, 12};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, c;
    bit stalled_prev, saw_block, fire_in;
    logic [31:0] y_prev;
    logic        ovf_prev;

    vecs[0]  = '{1'b0, 32'h00000001, 32'h3F800000, 1'b0};
    vecs[1]  = '{1'b0, 32'hFFFFFFFD, 32'hC0400000, 1'b0};
    vecs[2]  = '{1'b0, 32'h00000000, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 32'h01000001, 32'h4B800000, 1'b0};
    vecs[4]  = '{1'b0, 32'h01000003, 32'h4B800002, 1'b0};
    vecs[5]  = '{1'b0, 32'h7FFFFFFF, 32'h4F000000, 1'b0};
    vecs[6]  = '{1'b0, 32'h80000000, 32'hCF000000, 1'b0};
    vecs[7]  = '{1'b1, 32'h40200000, 32'h00000002, 1'b0};
    vecs[8]  = '{1'b1, 32'h40600000, 32'h00000004, 1'b0};
    vecs[9]  = '{1'b1, 32'hBFC00000, 32'hFFFFFFFE, 1'b0};
    vecs[10] = '{1'b1, 32'h3F000000, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 32'h4F000000, 32'h7FFFFFFF, 1'b1};
    vecs[12] = '{1'b1, 32'hCF000000, 32'h80000000, 1'b0};
    vecs[13] = '{1'b1, 32'h7FC00000, 32'h7FFFFFFF, 1'b1};
    vecs[14] = '{1'b1, 32'hFF800000, 32'h80000000, 1'b1};
    vecs[15] = '{1'b1, 32'h00000001, 32'h00000000, 1'b0};  // denormal
    vecs[16] = '{1'b1, 32'h3E800000, 32'h00000000, 1'b0};  // 0.25
    vecs[17] = '{1'b1, 32'h3F400000, 32'h00000001, 1'b0};  // 0.75
    vecs[18] = '{1'b1, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0};  // largest < 2^31
    vecs[19] = '{1'b1, 32'hCF000001, 32'h80000000, 1'b1};  // just below -2^31
    vecs[20] = '{1'b0, 32'h00FFFFFF, 32'h4B7FFFFF, 1'b0};
    vecs[21] = '{1'b1, 32'h4B000001, 32'h00800001, 1'b0};
    vecs[22] = '{1'b1, 32'hC0000000, 32'hFFFFFFFE, 1'b0};
    vecs[23] = '{1'b1, 32'h7F800000, 32'h7FFFFFFF, 1'b1};

    rst = 1'b1; in_valid = 1'b0; op_in = 1'b0; x = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset y", y, 32'd0);
    check("reset ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Backpressure: 8 ops streamed, consumer stalls in cycles 4..9.
    sent = 0; recv = 0; stalled_prev = 0; saw_block = 0;
    y_prev = 32'd0; ovf_prev = 1'b0;
    for (c = 0; c < 60 && recv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 9);
      if (sent < 8) begin
        in_valid = 1'b1;
        op_in    = vecs[ids[sent]].op;
        x        = vecs[ids[sent]].x;
      end else begin
        in_valid = 1'b0;
        x        = 32'd0;
      end
      #1;
      if (stalled_prev) begin
        check($sformatf("bp c%0d held valid", c), {31'd0, out_valid}, 32'd1);
        check($sformatf("bp c%0d held y", c), y, y_prev);
        check($sformatf("bp c%0d held ovf", c), {31'd0, ovf}, {31'd0, ovf_prev});
      end
      if (in_valid && !in_ready && !saw_block) begin
        saw_block = 1;
        check("bp occupancy at block", sent - recv, 32'd3);
      end
      if (out_valid && out_ready) begin
        $display("bp c%0d out#%0d y=%h ovf=%0d (expect %h/%0d)", c, recv, y, ovf,
                 vecs[ids[recv]].y, vecs[ids[recv]].ovf);
        check($sformatf("bp out%0d y", recv), y, vecs[ids[recv]].y);
        check($sformatf("bp out%0d ovf", recv), {31'd0, ovf}, {31'd0, vecs[ids[recv]].ovf});
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      y_prev   = y;
      ovf_prev = ovf;
      fire_in  = in_valid && in_ready;
      @(posedge clk);
      if (fire_in) sent++;
    end
    check("bp all received", recv, 32'd8);
    check("bp in_ready dropped", {31'd0, saw_block}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp no duplicate", {31'd0, out_valid}, 32'd0);

    // Reset with three ops in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_in    = vecs[3 + 2 * k].op;
      x        = vecs[3 + 2 * k].x;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rst pipe full valid", {31'd0, out_valid}, 32'd1);
    check("rst pipe full in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("mid-stream reset: out_valid=%0d y=%h ovf=%0d in_ready=%0d", out_valid, y, ovf, in_ready);
    check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst mid y", y, 32'd0);
    check("rst mid ovf", {31'd0, ovf}, 32'd0);
    check("rst mid in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst no stale output", {31'd0, out_valid}, 32'd0);
    run_vec(9);
    run_vec(19);
    run_vec(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
